// File: rtl/stopwatch_display.sv
// Multiplexed 4-digit common-anode seven-segment driver for the stopwatch digit chain.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (d0 always shown).
module stopwatch_display #(
    parameter int nBit   = 18,
    parameter int DP_POS = 2
) (
    input  logic            clk_base,
    input  logic            reset,
    input  logic [nBit-1:0] limit,
    input  logic            hold,
    input  logic [3:0]      d0,
    input  logic [3:0]      d1,
    input  logic [3:0]      d2,
    input  logic [3:0]      d3,
    output logic [3:0]      an,
    output logic [6:0]      seg,
    output logic            dp
);

    localparam logic [nBit-1:0] ONE = {{(nBit-1){1'b0}}, 1'b1};

    logic [nBit-1:0] cnt;
    logic [1:0]      idx;
    logic [15:0]     snap;
    logic            tick;
    logic [3:0]      cur_digit;
    logic            blank;
    logic [6:0]      seg_nxt;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    // >= (not ==) so a limit lowered below cnt wraps immediately
    assign tick      = (cnt >= limit);
    assign cur_digit = snap[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // lz[i]: digit i and every more-significant digit are zero
    logic [3:0] lz;
    assign lz[3] = (snap[15:12] == 4'd0);
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lz
            assign lz[gi] = lz[gi+1] && (snap[4*gi +: 4] == 4'd0);
        end
    endgenerate
    assign blank = (idx != 2'd0) && lz[idx];
`else
    assign blank = 1'b0;
`endif

    assign seg_nxt = blank ? 7'b1111111 : decode(cur_digit);

    always_ff @(posedge clk_base) begin
        if (!reset) begin
            cnt  <= '0;
            idx  <= 2'd0;
            snap <= 16'h0000;
            an   <= 4'b1111;
            seg  <= 7'b1111111;
            dp   <= 1'b1;
        end else begin
            cnt <= tick ? '0 : cnt + ONE;
            if (tick)
                idx <= idx + 2'd1;
            if (!hold)
                snap <= {d3, d2, d1, d0};
            an  <= ~(4'b0001 << idx);
            seg <= seg_nxt;
            dp  <= (idx != 2'(DP_POS));
        end
    end

endmodule
